// File: rtl/dat_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : dat_resp_if
// Description : Core data-port bus plus console / mailbox side signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface dat_resp_if;
    logic [15:0] dat_a;
    logic [3:0]  dat_we;
    logic [31:0] dat_wd;
    logic [3:0]  dat_re;
    logic [31:0] dat_rd;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tohost_valid;
    logic [31:0] tohost;

    modport master (
        output dat_a, dat_we, dat_wd, dat_re, tx_ready,
        input  dat_rd, tx_valid, tx_data, tohost_valid, tohost
    );

    modport slave (
        input  dat_a, dat_we, dat_wd, dat_re, tx_ready,
        output dat_rd, tx_valid, tx_data, tohost_valid, tohost
    );
endinterface
`default_nettype wire

// File: rtl/dat_resp.sv
`default_nettype none
// ============================================================================
// Module      : dat_resp
// Description : Data-side responder: byte-writable RAM, console TX FIFO,
//               cycle timer and tohost mailbox behind one SRAM-style port.
// Revision    : 1.0 - initial release
// ============================================================================
module dat_resp #(
    parameter int DEPTH_WORDS = 4096,
    parameter int TXQ_DEPTH   = 8
) (
    input  wire logic   clk,
    input  wire logic   rstn,
    dat_resp_if.slave   bus
);

    localparam int          c_AW     = $clog2(DEPTH_WORDS);
    localparam int          c_QW     = $clog2(TXQ_DEPTH);
    localparam int          c_CW     = c_QW + 1;
    localparam logic [13:0] c_TXDATA = 14'h3FC0;
    localparam logic [13:0] c_TXSTAT = 14'h3FC1;
    localparam logic [13:0] c_MTIME  = 14'h3FC2;
    localparam logic [13:0] c_TOHOST = 14'h3FC3;

    logic [31:0]     r_mem [DEPTH_WORDS];
    logic [31:0]     r_rd;
    logic [31:0]     r_mtime;
    logic [31:0]     r_tohost;
    logic            r_tohost_valid;
    logic [7:0]      r_txq [TXQ_DEPTH];
    logic [c_QW-1:0] r_head;
    logic [c_QW-1:0] r_tail;
    logic [c_CW-1:0] r_count;
    logic            r_ovf;

    logic [13:0]     w_word;
    logic [c_AW-1:0] w_ram_idx;
    logic            w_ram_hit;
    logic            w_any_we;
    logic [31:0]     w_wmask;
    logic [31:0]     w_rmask;
    logic [31:0]     w_rdata;
    logic [31:0]     w_stat;
    logic [31:0]     w_cnt32;
    logic            w_full;
    logic            w_tx_valid;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;
    logic            w_unused;

    assign w_word    = bus.dat_a[15:2];
    assign w_ram_idx = bus.dat_a[c_AW+1:2];
    assign w_ram_hit = (bus.dat_a[15:c_AW+2] == '0);
    assign w_any_we  = rstn && (bus.dat_we != 4'b0000);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign w_wmask[8*i +: 8] = {8{bus.dat_we[i]}};
        assign w_rmask[8*i +: 8] = {8{bus.dat_re[i]}};
    end

    // Pop is qualified by a non-empty queue, so a full queue can accept a
    // push in the same cycle that its head drains.
    assign w_full     = (r_count == c_CW'(TXQ_DEPTH));
    assign w_tx_valid = (r_count != '0);
    assign w_pop      = w_tx_valid && bus.tx_ready;
    assign w_push_req = rstn && !w_ram_hit && (w_word == c_TXDATA) && bus.dat_we[0];
    assign w_push     = w_push_req && (!w_full || w_pop);

    assign w_cnt32 = 32'(r_count);
    assign w_stat  = {24'h000000, w_cnt32[3:0], 2'b00, r_ovf, w_full};

    always_comb begin
        w_rdata = '0;
        if (w_ram_hit) begin
            w_rdata = r_mem[w_ram_idx];
        end else begin
            case (w_word)
                c_TXSTAT: w_rdata = w_stat;
                c_MTIME:  w_rdata = r_mtime;
                c_TOHOST: w_rdata = r_tohost;
                default:  w_rdata = '0;
            endcase
        end
    end

    // RAM is deliberately outside reset; reads see the pre-write word.
    always_ff @(posedge clk) begin
        if (w_any_we && w_ram_hit) begin
            r_mem[w_ram_idx] <= (r_mem[w_ram_idx] & ~w_wmask) | (bus.dat_wd & w_wmask);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd <= '0;
        end else if (bus.dat_re != 4'b0000) begin
            r_rd <= w_rdata & w_rmask;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_txq[r_tail] <= bus.dat_wd[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_QW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_QW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_any_we && !w_ram_hit && (w_word == c_TXSTAT)) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // A timer write replaces that cycle's increment.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_mtime <= '0;
        end else if (w_any_we && !w_ram_hit && (w_word == c_MTIME)) begin
            r_mtime <= (r_mtime & ~w_wmask) | (bus.dat_wd & w_wmask);
        end else begin
            r_mtime <= r_mtime + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tohost       <= '0;
            r_tohost_valid <= 1'b0;
        end else if (w_any_we && !w_ram_hit && (w_word == c_TOHOST)) begin
            r_tohost       <= (r_tohost & ~w_wmask) | (bus.dat_wd & w_wmask);
            r_tohost_valid <= 1'b1;
        end
    end

    assign bus.dat_rd       = r_rd;
    assign bus.tx_valid     = w_tx_valid;
    assign bus.tx_data      = r_txq[r_head];
    assign bus.tohost       = r_tohost;
    assign bus.tohost_valid = r_tohost_valid;

    assign w_unused = ^{bus.dat_a[1:0], w_cnt32[31:4]};

endmodule
`default_nettype wire

// File: tb/tb_dat_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_dat_resp
// Description : Scoreboard bench for dat_resp with a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dat_resp;

    localparam int DW = 256;
    localparam int TQ = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dat_resp_if bus();

    dat_resp #(.DEPTH_WORDS(DW), .TXQ_DEPTH(TQ)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Reference state
    logic [31:0] m_mem [DW];
    logic [7:0]  m_txq [$];
    logic [7:0]  exp_tx [$];
    logic [31:0] exp_rd [$];
    logic [31:0] m_mtime  = '0;
    logic [31:0] m_tohost = '0;
    bit          m_tv     = 1'b0;
    bit          m_ovf    = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;
    bit pend   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h required %08h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] en);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (en[i]) m |= (32'hFF << (8 * i));
        return m;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] en);
        return (o & ~lanes(en)) | (n & lanes(en));
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        int unsigned ad = 32'(a);
        int unsigned rg = ad & 32'hFFFC;
        int unsigned sz = 32'(m_txq.size());
        if (ad < 4 * DW) return m_mem[ad / 4];
        case (rg)
            32'hFF04: return sz * 16 + (m_ovf ? 2 : 0) + ((sz == TQ) ? 1 : 0);
            32'hFF08: return m_mtime;
            32'hFF0C: return m_tohost;
            default:  return 32'h0;
        endcase
    endfunction

    // Apply the edge just taken to the reference, using the inputs still held.
    task automatic model_step();
        int unsigned ad = 32'(bus.dat_a);
        int unsigned rg = ad & 32'hFFFC;
        logic [3:0]  we = bus.dat_we;
        logic [31:0] wd = bus.dat_wd;
        int          pre;
        bit          pop;
        if (!rstn) begin
            exp_rd.push_back(32'h0);
            m_txq.delete();
            exp_tx.delete();
            m_ovf = 0; m_mtime = '0; m_tohost = '0; m_tv = 0;
            return;
        end
        if (bus.dat_re != 4'b0000) exp_rd.push_back(model_read(bus.dat_a) & lanes(bus.dat_re));
        pre = m_txq.size();
        pop = (pre > 0) && bus.tx_ready;
        if (pop) void'(m_txq.pop_front());
        if (rg == 32'hFF00 && we[0]) begin
            if (pre < TQ || pop) begin
                m_txq.push_back(wd[7:0]);
                exp_tx.push_back(wd[7:0]);
            end else begin
                m_ovf = 1;
            end
        end
        if (rg == 32'hFF04 && we != 0) m_ovf = 0;
        if (rg == 32'hFF08 && we != 0) m_mtime = merge(m_mtime, wd, we);
        else                           m_mtime = m_mtime + 1;
        if (rg == 32'hFF0C && we != 0) begin
            m_tohost = merge(m_tohost, wd, we);
            m_tv     = 1;
        end
        if (ad < 4 * DW && we != 0) m_mem[ad / 4] = merge(m_mem[ad / 4], wd, we);
    endtask

    task automatic cycle(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                         input logic [3:0] re, input bit rdy, input bit rs);
        bus.dat_a    = a;
        bus.dat_we   = we;
        bus.dat_wd   = wd;
        bus.dat_re   = re;
        bus.tx_ready = rdy;
        rstn         = rs;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input bit rdy);
        cycle(16'h8000, 4'h0, 32'h0, 4'h0, rdy, 1'b1);
    endtask

    task automatic drain();
        int k = 0;
        while (bus.tx_valid && k < 20) begin
            idle(1'b1);
            k++;
        end
        chk("tx_drain_done", 32'(bus.tx_valid), 32'h0);
    endtask

    // Monitor: read data one edge after a read (or reset), plus side outputs.
    always @(posedge clk) pend <= (bus.dat_re != 4'b0000) || !rstn;

    always @(negedge clk) begin
        if (pend) begin
            if (exp_rd.size() == 0) chk("dat_rd_unexpected", 32'h1, 32'h0);
            else                    chk("dat_rd", bus.dat_rd, exp_rd.pop_front());
        end
        if (mon_on) begin
            chk("tx_valid", 32'(bus.tx_valid), 32'(m_txq.size() != 0));
            chk("tohost_valid", 32'(bus.tohost_valid), 32'(m_tv));
            chk("tohost", bus.tohost, m_tohost);
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_tx.size() == 0) chk("tx_data_unexpected", 32'h1, 32'h0);
                else                    chk("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
            end
        end
    end

    initial begin
        logic [15:0] a;
        int          r;

        bus.dat_a = '0; bus.dat_we = '0; bus.dat_wd = '0; bus.dat_re = '0; bus.tx_ready = 1'b0;

        // Reset with reads presented: they must be ignored.
        repeat (3) cycle(16'h0010, 4'h0, 32'h0, 4'hF, 1'b0, 1'b0);
        mon_on = 1'b1;
        chk("reset_dat_rd", bus.dat_rd, 32'h0);
        chk("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("reset_tohost_valid", 32'(bus.tohost_valid), 32'h0);

        for (int i = 0; i < DW; i++) cycle(16'(i * 4), 4'hF, $urandom, 4'h0, 1'b0, 1'b1);

        // RAM byte lanes
        cycle(16'h0010, 4'hF, 32'hAABBCCDD, 4'h0, 1'b0, 1'b1);
        cycle(16'h0010, 4'b0010, 32'h00001100, 4'h0, 1'b0, 1'b1);
        cycle(16'h0010, 4'h0, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("ram_lanes_full", bus.dat_rd, 32'hAABB11DD);
        cycle(16'h0010, 4'h0, 32'h0, 4'b0001, 1'b0, 1'b1);
        chk("ram_lane0_only", bus.dat_rd, 32'h000000DD);

        // Read-before-write
        cycle(16'h0020, 4'hF, 32'h0, 4'h0, 1'b0, 1'b1);
        cycle(16'h0020, 4'hF, 32'h12345678, 4'hF, 1'b0, 1'b1);
        chk("rbw_old", bus.dat_rd, 32'h0);
        cycle(16'h0020, 4'h0, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("rbw_new", bus.dat_rd, 32'h12345678);

        // FIFO fill, overflow, drain, clear
        for (int i = 0; i < 9; i++) cycle(16'hFF00, 4'h1, 32'(8'h41 + i), 4'h0, 1'b0, 1'b1);
        cycle(16'hFF04, 4'h0, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("txstat_full_ovf", bus.dat_rd, 32'h83);
        drain();
        cycle(16'hFF04, 4'h0, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("txstat_ovf_sticky", bus.dat_rd, 32'h02);
        cycle(16'hFF04, 4'hF, 32'h0, 4'h0, 1'b0, 1'b1);
        cycle(16'hFF04, 4'h0, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("txstat_ovf_clear", bus.dat_rd, 32'h00);

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 8; i++) cycle(16'hFF00, 4'h1, 32'(8'h30 + i), 4'h0, 1'b0, 1'b1);
        cycle(16'hFF00, 4'h1, 32'h5A, 4'h0, 1'b1, 1'b1);
        cycle(16'hFF04, 4'h0, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("txstat_full_pushpop", bus.dat_rd, 32'h81);
        drain();

        // MTIME wrap
        cycle(16'hFF08, 4'hF, 32'hFFFFFFFE, 4'h0, 1'b0, 1'b1);
        idle(1'b0);
        cycle(16'hFF08, 4'h0, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("mtime_max", bus.dat_rd, 32'hFFFFFFFF);
        cycle(16'hFF08, 4'h0, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("mtime_wrap", bus.dat_rd, 32'h0);

        // Mailbox, then reset during a pending read
        cycle(16'hFF0C, 4'hF, 32'h1, 4'h0, 1'b0, 1'b1);
        chk("tohost_valid_set", 32'(bus.tohost_valid), 32'h1);
        chk("tohost_value", bus.tohost, 32'h1);
        cycle(16'hFF00, 4'h1, 32'h77, 4'h0, 1'b0, 1'b1);
        cycle(16'h0010, 4'h0, 32'h0, 4'hF, 1'b0, 1'b1);
        cycle(16'h0010, 4'h0, 32'h0, 4'hF, 1'b0, 1'b0);
        chk("rst_dat_rd", bus.dat_rd, 32'h0);
        chk("rst_tohost_valid", 32'(bus.tohost_valid), 32'h0);
        chk("rst_tohost", bus.tohost, 32'h0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        cycle(16'hFF08, 4'h0, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("rst_mtime", bus.dat_rd, 32'h0);
        cycle(16'h0010, 4'h0, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("rst_ram_kept", bus.dat_rd, 32'hAABB11DD);

        // Randomized traffic across all targets
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      a = 16'($urandom_range(0, DW - 1) * 4 + $urandom_range(0, 3));
            else if (r < 85) a = 16'(32'hFF00 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
            else if (r < 93) a = 16'($urandom_range(32'h0400, 32'hFEFF));
            else             a = 16'($urandom_range(32'hFF10, 32'hFFFF));
            cycle(a,
                  $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0,
                  $urandom,
                  $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 199) != 0);
        end

        idle(1'b0);
        idle(1'b0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
